// File: rtl/q_round_inverse_seq.sv
// Sequential inverse of the Salsa20/8 quarter round: recovers (x0..x3) from
// (y0..y3) by undoing the four forward steps in reverse, STEPS_PER_CYCLE at a time.
module q_round_inverse_seq #(
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] y0,
  input  logic [31:0] y1,
  input  logic [31:0] y2,
  input  logic [31:0] y3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] x0,
  output logic [31:0] x1,
  output logic [31:0] x2,
  output logic [31:0] x3,
  output logic        busy
);

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned N_STEPS = 4;
  localparam int unsigned CNT_W   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   step_cnt, step_cnt_nxt;
  logic [WORD_W-1:0]  w0, w1, w2, w3;
  logic [WORD_W-1:0]  w0_nxt, w1_nxt, w2_nxt, w3_nxt;
  logic [WORD_W-1:0]  x0_nxt, x1_nxt, x2_nxt, x3_nxt;
  logic [WORD_W-1:0]  c0, c1, c2, c3;
  logic               last_c;

  function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] v,
                                             input int unsigned n);
    return (v << n) | (v >> (WORD_W - n));
  endfunction

  // Combinational chain of the sub-steps due this cycle, in A-B-C-D order.
  always_comb begin
    c0 = w0;
    c1 = w1;
    c2 = w2;
    c3 = w3;
    for (int unsigned i = 0; i < STEPS_PER_CYCLE; i++) begin
      case (CNT_W'(32'(step_cnt) + i))
        2'd0:    c3 = c3 ^ rotl(c2 + c1, 18);
        2'd1:    c2 = c2 ^ rotl(c1 + c0, 13);
        2'd2:    c1 = c1 ^ rotl(c0 + c3, 9);
        default: c0 = c0 ^ rotl(c3 + c2, 7);
      endcase
    end
    last_c = (32'(step_cnt) + STEPS_PER_CYCLE) >= N_STEPS;
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_nxt    = state;
    step_cnt_nxt = step_cnt;
    w0_nxt       = w0;
    w1_nxt       = w1;
    w2_nxt       = w2;
    w3_nxt       = w3;
    x0_nxt       = x0;
    x1_nxt       = x1;
    x2_nxt       = x2;
    x3_nxt       = x3;
    case (state)
      IDLE: begin
        if (in_valid) begin
          w0_nxt       = y0;
          w1_nxt       = y1;
          w2_nxt       = y2;
          w3_nxt       = y3;
          step_cnt_nxt = '0;
          state_nxt    = COMPUTE;
        end
      end
      COMPUTE: begin
        w0_nxt       = c0;
        w1_nxt       = c1;
        w2_nxt       = c2;
        w3_nxt       = c3;
        step_cnt_nxt = step_cnt + CNT_W'(STEPS_PER_CYCLE);
        if (last_c) begin
          x0_nxt    = c0;
          x1_nxt    = c1;
          x2_nxt    = c2;
          x3_nxt    = c3;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      step_cnt  <= '0;
      w0        <= '0;
      w1        <= '0;
      w2        <= '0;
      w3        <= '0;
      x0        <= '0;
      x1        <= '0;
      x2        <= '0;
      x3        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      step_cnt  <= step_cnt_nxt;
      w0        <= w0_nxt;
      w1        <= w1_nxt;
      w2        <= w2_nxt;
      w3        <= w3_nxt;
      x0        <= x0_nxt;
      x1        <= x1_nxt;
      x2        <= x2_nxt;
      x3        <= x3_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_q_round_inverse_seq.sv
// Bench for q_round_inverse_seq: three instances (1, 2, 4 steps/cycle) share stimulus;
// a transaction-level round-trip model predicts handshakes and results every cycle.
module tb_q_round_inverse_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [31:0] y0 = '0, y1 = '0, y2 = '0, y3 = '0;
  logic [2:0] in_ready, out_valid, busy;
  logic [2:0][31:0] x0v, x1v, x2v, x3v;
  logic [127:0] want = '0;

  int n_vec = 0;
  int n_err = 0;

  localparam int LAT [3] = '{4, 2, 1};
  localparam logic [127:0] LIT_Y = 128'h00000080_00010200_20500000_08008145;
  localparam logic [127:0] LIT_X = 128'h00000000_00000000_00000000_00000001;

  always #5 clk = ~clk;

  q_round_inverse_seq #(.STEPS_PER_CYCLE(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .out_valid(out_valid[0]), .out_ready(out_ready),
    .x0(x0v[0]), .x1(x1v[0]), .x2(x2v[0]), .x3(x3v[0]), .busy(busy[0]));
  q_round_inverse_seq #(.STEPS_PER_CYCLE(2)) dut_s2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .out_valid(out_valid[1]), .out_ready(out_ready),
    .x0(x0v[1]), .x1(x1v[1]), .x2(x2v[1]), .x3(x3v[1]), .busy(busy[1]));
  q_round_inverse_seq #(.STEPS_PER_CYCLE(4)) dut_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .out_valid(out_valid[2]), .out_ready(out_ready),
    .x0(x0v[2]), .x1(x1v[2]), .x2(x2v[2]), .x3(x3v[2]), .busy(busy[2]));

  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Forward quarter round; the block under test must undo exactly this.
  function automatic logic [127:0] fwd(input logic [127:0] x);
    logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3;
    {a0, a1, a2, a3} = x;
    b0 = a0 ^ rl(a3 + a2, 7);
    b1 = a1 ^ rl(b0 + a3, 9);
    b2 = a2 ^ rl(b1 + b0, 13);
    b3 = a3 ^ rl(b2 + b1, 18);
    return {b0, b1, b2, b3};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  // Model: idle(0) -> accept -> LAT edges computing(1) -> done(2) until out_ready.
  int mst [3] = '{0, 0, 0};
  int mcnt [3] = '{0, 0, 0};
  logic [127:0] mex [3] = '{'0, '0, '0};
  logic [127:0] mpend [3] = '{'0, '0, '0};

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        mst[k]   <= 0;
        mcnt[k]  <= 0;
        mex[k]   <= '0;
        mpend[k] <= '0;
      end else begin
        case (mst[k])
          0: if (in_valid) begin
            mst[k]   <= 1;
            mcnt[k]  <= LAT[k];
            mpend[k] <= want;
          end
          1: begin
            mcnt[k] <= mcnt[k] - 1;
            if (mcnt[k] == 1) begin
              mst[k] <= 2;
              mex[k] <= mpend[k];
            end
          end
          default: if (out_ready) mst[k] <= 0;
        endcase
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic [130:0] got, exp;
      got = {in_ready[k], out_valid[k], busy[k], x0v[k], x1v[k], x2v[k], x3v[k]};
      exp = {mst[k] == 0, mst[k] == 2, mst[k] != 0, mex[k]};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL cycle_cmp dut%0d t=%0t got rdy/vld/bsy=%b%b%b x=%h expected %b%b%b x=%h",
                 k, $time, got[130], got[129], got[128], got[127:0],
                 exp[130], exp[129], exp[128], exp[127:0]);
      end
    end
  end

  function automatic logic all_idle();
    return (mst[0] == 0) && (mst[1] == 0) && (mst[2] == 0);
  endfunction

  // Called at a negedge; returns at a negedge with every instance idle.
  task automatic wait_idle(input bool_stall);
    int i;
    i = 0;
    while (!all_idle() && i < 40) begin
      out_ready = bool_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      i++;
    end
    out_ready = 1'b1;
    if (!all_idle()) check("wait_idle_timeout", 128'd0, 128'd1);
  endtask

  // Single request with out_ready held high; measures accept-to-valid latency.
  task automatic directed(input string name, input logic [127:0] yv, input logic [127:0] xv);
    int lat [3];
    lat = '{0, 0, 0};
    in_valid = 1'b1;
    {y0, y1, y2, y3} = yv;
    want = xv;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++)
        if (lat[k] == 0 && out_valid[k]) lat[k] = e;
    end
    for (int k = 0; k < 3; k++) begin
      check({name, "_lat"}, 128'(lat[k]), 128'(LAT[k]));
      check({name, "_x"}, {x0v[k], x1v[k], x2v[k], x3v[k]}, xv);
    end
    @(negedge clk);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog t=%0t got=no_finish expected=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] xr, x2;
    // Pin the forward model itself.
    check("pin_fwd_lit", fwd(LIT_X), LIT_Y);
    check("pin_fwd_zero", fwd(128'd0), 128'd0);

    repeat (2) @(negedge clk);
    check("reset_rdy_vld_bsy", {122'd0, in_ready, out_valid, busy}, {122'd0, 3'b111, 3'b000, 3'b000});

    // Release reset and accept on the very first edge.
    rst = 1'b0;
    directed("zero", 128'd0, 128'd0);
    directed("lit", LIT_Y, LIT_X);
    directed("ones", fwd({4{32'hFFFF_FFFF}}), {4{32'hFFFF_FFFF}});
    directed("mixed", fwd(128'hDEADBEEF_01234567_89ABCDEF_80000000),
             128'hDEADBEEF_01234567_89ABCDEF_80000000);

    // Hold result with out_ready low while a different request is pending.
    x2 = 128'h11223344_55667788_99AABBCC_DDEEFF00;
    out_ready = 1'b0;
    in_valid = 1'b1;
    {y0, y1, y2, y3} = LIT_Y;
    want = LIT_X;
    @(posedge clk);
    #1 {y0, y1, y2, y3} = fwd(x2);
    want = x2;
    repeat (14) @(negedge clk);
    check("hold_vld", {125'd0, out_valid}, {125'd0, 3'b111});
    check("hold_rdy", {125'd0, in_ready}, 128'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 check("hold_release_idle", {125'd0, busy}, 128'd0);
    @(posedge clk);
    #1 check("hold_next_accept", {125'd0, busy}, {125'd0, 3'b111});
    in_valid = 1'b0;
    @(negedge clk);
    wait_idle(1'b0);
    for (int k = 0; k < 3; k++)
      check("hold_second_x", {x0v[k], x1v[k], x2v[k], x3v[k]}, x2);

    // Asynchronous reset two edges after accept.
    in_valid = 1'b1;
    {y0, y1, y2, y3} = LIT_Y;
    want = LIT_X;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("abort_vld_bsy", {122'd0, in_ready, out_valid, busy}, {122'd0, 3'b111, 6'd0});
    for (int k = 0; k < 3; k++)
      check("abort_x", {x0v[k], x1v[k], x2v[k], x3v[k]}, 128'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    directed("after_abort", LIT_Y, LIT_X);

    // Random round trips; early ones also stall the consumer.
    for (int n = 0; n < 10000; n++) begin
      xr = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1;
      {y0, y1, y2, y3} = fwd(xr);
      want = xr;
      @(negedge clk);
      in_valid = 1'b0;
      wait_idle(n < 1000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/q_round_inverse_seq.md
Q_ROUND_INVERSE_SEQ -- requirements
Module: q_round_inverse_seq

Interface
REQ-001 Parameter: STEPS_PER_CYCLE, default 1, number of inverse sub-steps done per compute cycle; legal values are 1, 2 and 4.
REQ-002 Port: clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 Port: rst, input, 1, asynchronous active-high reset.
REQ-004 Port: in_valid, input, 1, y0..y3 hold a request.
REQ-005 Port: in_ready, output, 1, the block accepts a request this cycle.
REQ-006 Port: y0, y1, y2, y3, input, 32 each, quarter-round output words to be inverted.
REQ-007 Port: out_valid, output, 1, x0..x3 hold a result.
REQ-008 Port: out_ready, input, 1, the consumer takes the result this cycle.
REQ-009 Port: x0, x1, x2, x3, output, 32 each, recovered quarter-round input words (registered).
REQ-010 Port: busy, output, 1, high in any state other than IDLE.

Function
REQ-011 The block SHALL compute the exact inverse of the Salsa20/8 quarter round.
- Forward round, rotl = rotate-left, + = mod 2^32:
  - y0 = x0^rotl(x3+x2,7)
  - y1 = x1^rotl(y0+x3,9)
  - y2 = x2^rotl(y1+y0,13)
  - y3 = x3^rotl(y2+y1,18)
REQ-012 Sub-steps SHALL run in this fixed order on working registers w0..w3, each updated in place:
- A: w3 = w3^rotl(w2+w1,18)
- B: w2 = w2^rotl(w1+w0,13)
- C: w1 = w1^rotl(w0+w3,9)
- D: w0 = w0^rotl(w3+w2,7)
REQ-013 All additions SHALL be 32-bit with carry-out discarded, and rotations SHALL be pure bit rotations, never shifts.
REQ-014 The FSM SHALL have the states IDLE, COMPUTE and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; all other states SHALL hold it at 0.
REQ-016 On an edge with in_valid=1 and in_ready=1, the block SHALL load w0..w3 from y0..y3, clear the step counter and go to COMPUTE.
REQ-017 Each COMPUTE edge SHALL apply the next STEPS_PER_CYCLE sub-steps, chained combinationally in A-B-C-D order.
REQ-018 After sub-step D the block SHALL go to DONE.
REQ-019 out_valid SHALL rise exactly 4/STEPS_PER_CYCLE edges after the accept edge: 4 for STEPS_PER_CYCLE=1, 2 for 2, 1 for 4.
REQ-020 In DONE, out_valid SHALL be 1 and x0..x3 SHALL equal w0..w3, held stable while out_ready=0.
REQ-021 An edge in DONE with out_ready=1 SHALL return the block to IDLE with out_valid=0.
- A new request SHALL NOT be accepted on that same edge; the throughput bound is one result per 4/STEPS_PER_CYCLE+2 cycles.
REQ-022 Outside IDLE, in_valid and y0..y3 SHALL be ignored and SHALL NOT affect w or x.
REQ-023 x0..x3 SHALL keep their last value outside DONE and SHALL be 0 after reset until the first result.
REQ-024 Feeding a forward quarter-round output through this block SHALL reproduce the forward input bit-exactly for every 128-bit value.

Reset
REQ-025 While rst=1 the block SHALL be in IDLE.
- in_ready=1 while reset is held (IDLE); out_valid=0, busy=0.
- x0..x3, w0..w3 and the step counter are all 0.
REQ-026 A reset asserted mid-COMPUTE or in DONE SHALL abort immediately and asynchronously.
- No partial result SHALL ever appear with out_valid=1.
REQ-027 The first accept after rst deasserts SHALL be possible on the first rising edge.

Verification
REQ-028 y=(0,0,0,0), STEPS_PER_CYCLE=1 -> x=(0,0,0,0), with out_valid rising 4 edges after accept.
REQ-029 y=(0x00000080,0x00010200,0x20500000,0x08008145) -> x=(0,0,0,1).
- Required for STEPS_PER_CYCLE 1, 2 and 4, with latencies 4, 2 and 1 respectively.
REQ-030 Hold out_ready=0 for 10 cycles after out_valid, with in_valid=1 and different y -> x stable, in_ready=0, no second accept.
- Then out_ready=1 for one cycle -> IDLE, and the next accept happens on the following edge.
REQ-031 Assert rst for one cycle, two edges after accept -> outputs return to reset values at once.
- No out_valid pulse.
- A later request y=(0x80,0x10200,0x20500000,0x08008145) still yields (0,0,0,1).
REQ-032 Random round-trip: 10000 random x, forward-computed y -> bit-exact x recovered.
- Protocol checks: no out_valid without a prior accept; x constant while out_valid=1 and out_ready=0.
